// File: rtl/ifetch.sv
// Instruction fetch: sequential PC generation, in-order memory requests,
// prefetch FIFO toward decode, redirect with stale-response dropping.
module ifetch #(
  parameter int PC_W = 32,
  parameter int INSTR_W = 32,
  parameter int FIFO_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               req_valid,
  input  logic               req_ready,
  output logic [PC_W-1:0]    req_addr,
  input  logic               rsp_valid,
  input  logic [INSTR_W-1:0] rsp_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [PC_W-1:0] STEP = PC_W'(4);
  localparam logic [CW+1:0] CREDITS = (CW+2)'(FIFO_DEPTH);

  logic [PC_W-1:0]    fetch_pc;
  logic [PC_W-1:0]    rsp_pc;
  logic [CW-1:0]      outstanding;
  logic [CW-1:0]      drop_cnt;
  logic [CW-1:0]      count;
  logic [AW-1:0]      rd_ptr;
  logic [AW-1:0]      wr_ptr;
  logic [PC_W-1:0]    pc_mem [FIFO_DEPTH];
  logic [INSTR_W-1:0] ins_mem [FIFO_DEPTH];

  logic [CW+1:0]   inflight;
  logic            hs;
  logic            rsp_live;
  logic            rsp_drop;
  logic            push;
  logic            pop;
  logic            bypass;
  logic [CW-1:0]   cnt_after_pop;
  logic [CW-1:0]   cnt_next;
  logic [AW-1:0]   rd_next;
  logic [PC_W-1:0] target;
  logic            unused_bits;

  // outstanding counts live requests, drop_cnt counts stale ones
  assign inflight = (CW+2)'(outstanding)
                  + (CW+2)'(drop_cnt)
                  + (CW+2)'(count);

  assign req_valid = rst_n && !redirect_valid
                  && (inflight < CREDITS);
  assign req_addr  = fetch_pc;
  assign hs        = req_valid && req_ready;

  assign rsp_drop = rsp_valid && (drop_cnt != '0);
  assign rsp_live = rsp_valid && (drop_cnt == '0)
                 && (outstanding != '0);
  assign push     = rsp_live && !redirect_valid;
  assign pop      = out_valid && out_ready;

  assign cnt_after_pop = count - CW'(pop);
  assign cnt_next      = cnt_after_pop + CW'(push);
  assign rd_next       = rd_ptr + AW'(pop);
  assign bypass        = push && (cnt_after_pop == '0);

  assign target      = {redirect_pc[PC_W-1:2], 2'b00};
  assign unused_bits = ^redirect_pc[1:0];

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]  <= rsp_pc;
      ins_mem[wr_ptr] <= rsp_instr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_instr   <= '0;
    end else if (redirect_valid) begin
      fetch_pc    <= target;
      rsp_pc      <= target;
      outstanding <= '0;
      drop_cnt    <= outstanding + drop_cnt
                   - CW'(rsp_live || rsp_drop);
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      out_valid   <= 1'b0;
    end else begin
      if (hs) fetch_pc <= fetch_pc + STEP;
      outstanding <= outstanding + CW'(hs)
                   - CW'(rsp_live);
      if (rsp_drop) drop_cnt <= drop_cnt - 1'b1;
      if (push) begin
        rsp_pc <= rsp_pc + STEP;
        wr_ptr <= wr_ptr + 1'b1;
      end
      rd_ptr    <= rd_next;
      count     <= cnt_next;
      out_valid <= (cnt_next != '0);
      // head comes from the incoming response when the FIFO drains to it
      if (bypass) begin
        out_pc    <= rsp_pc;
        out_instr <= rsp_instr;
      end else if (cnt_after_pop != '0) begin
        out_pc    <= pc_mem[rd_next];
        out_instr <= ins_mem[rd_next];
      end
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(push && count == CW'(FIFO_DEPTH))
  );

endmodule
